// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester ports, memory port and status of the arbiter.
// master is the arbiter's view; slave is the requesters' and memory's view.
interface mem_port_arbiter_if #(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int MW = DATA_WIDTH / 8;

   logic [NUM_PORTS-1:0]            req_read;
   logic [NUM_PORTS-1:0]            req_write;
   logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address;
   logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_PORTS*MW-1:0]         req_wmask;
   logic [NUM_PORTS-1:0]            req_resp;
   logic [DATA_WIDTH-1:0]           req_rdata;

   logic                            mem_read;
   logic                            mem_write;
   logic [ADDR_WIDTH-1:0]           mem_address;
   logic [DATA_WIDTH-1:0]           mem_wdata;
   logic [MW-1:0]                   mem_wmask;
   logic                            mem_resp;
   logic [DATA_WIDTH-1:0]           mem_rdata;

   logic                            busy;
   logic [GW-1:0]                   grant_id;

   modport master (
      input  req_read, req_write, req_address, req_wdata, req_wmask,
      input  mem_resp, mem_rdata,
      output req_resp, req_rdata,
      output mem_read, mem_write, mem_address, mem_wdata, mem_wmask,
      output busy, grant_id
   );

   modport slave (
      output req_read, req_write, req_address, req_wdata, req_wmask,
      output mem_resp, mem_rdata,
      input  req_resp, req_rdata,
      input  mem_read, mem_write, mem_address, mem_wdata, mem_wmask,
      input  busy, grant_id
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: N requesters share one memory port, one transaction at a time.
// Round-robin by default; define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module mem_port_arbiter #(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic                clk,
   input logic                rst,
   mem_port_arbiter_if.master bus
);
   localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int MW = DATA_WIDTH / 8;
   localparam logic [GW-1:0] LAST = GW'(NUM_PORTS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t               state;
   logic                 busy_q;
   logic [GW-1:0]        grant_q;
   logic [GW-1:0]        winner;
   logic [NUM_PORTS-1:0] req_any;
   logic                 any_req;
   logic                 active;

   assign req_any = bus.req_read | bus.req_write;
   assign any_req = |req_any;
   // Reset overrides an in-flight transaction: nothing reaches memory or ports.
   assign active  = busy_q & ~rst;

`ifdef MEM_ARB_FIXED_PRIO_EN
   // Lowest requesting index wins; scanning downward leaves the lowest.
   always_comb begin
      winner = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (req_any[i]) winner = GW'(i);
      end
   end
`else
   logic [GW-1:0] rr_ptr;
   logic [GW-1:0] rr_next;

   // First requester at or after rr_ptr, wrapping; downward scan keeps the nearest.
   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (req_any[idx]) winner = GW'(idx);
      end
   end

   assign rr_next = (grant_q == LAST) ? '0 : grant_q + GW'(1);
`endif

   // Control FSM: grant on an idle request, release on mem_resp.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         busy_q  <= 1'b0;
         grant_q <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
         rr_ptr  <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  state   <= BUSY;
                  busy_q  <= 1'b1;
                  grant_q <= winner;
               end
            end
            BUSY: begin
               if (bus.mem_resp) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
                  rr_ptr <= rr_next;
`endif
               end
            end
         endcase
      end
   end

   // Steer the granted port to memory and route its completion pulse.
   always_comb begin
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.mem_address = '0;
      bus.mem_wdata   = '0;
      bus.mem_wmask   = '0;
      bus.req_resp    = '0;
      if (active) begin
         bus.mem_write   = bus.req_write[grant_q];
         bus.mem_read    = bus.req_read[grant_q]
                         & ~bus.req_write[grant_q];
         bus.mem_address =
            bus.req_address[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
         bus.mem_wdata   =
            bus.req_wdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
         bus.mem_wmask   =
            bus.req_wmask[int'(grant_q)*MW +: MW];
         bus.req_resp[grant_q] = bus.mem_resp;
      end
   end

   assign bus.req_rdata = bus.mem_rdata;
   assign bus.busy      = active;
   assign bus.grant_id  = grant_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a queue-free per-port request model.
module tb_mem_port_arbiter;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = DW / 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(
      .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
   ) bus ();

   mem_port_arbiter #(
      .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int m_ptr    = 0;

   logic          p_rd [N];
   logic          p_wr [N];
   logic [AW-1:0] p_a  [N];
   logic [DW-1:0] p_d  [N];
   logic [MW-1:0] p_m  [N];

   // Reference arbitration: who should win among mask, given the pointer.
   function automatic int pick(logic [N-1:0] mask, int ptr);
`ifdef MEM_ARB_FIXED_PRIO_EN
      for (int i = 0; i < N; i++) if (mask[i]) return i;
`else
      for (int k = 0; k < N; k++) if (mask[(ptr + k) % N]) return (ptr + k) % N;
`endif
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_port(int p);
      bus.req_read[p]             = p_rd[p];
      bus.req_write[p]            = p_wr[p];
      bus.req_address[p*AW +: AW] = p_a[p];
      bus.req_wdata[p*DW +: DW]   = p_d[p];
      bus.req_wmask[p*MW +: MW]   = p_m[p];
   endtask

   task automatic load(int p, logic rd, logic wr, logic [AW-1:0] a,
                       logic [DW-1:0] d, logic [MW-1:0] m);
      p_rd[p] = rd; p_wr[p] = wr; p_a[p] = a; p_d[p] = d; p_m[p] = m;
      drive_port(p);
   endtask

   task automatic drop(int p);
      load(p, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic clear_all();
      for (int p = 0; p < N; p++) drop(p);
      bus.mem_resp  = 1'b0;
      bus.mem_rdata = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_all();
      tick();
      tick();
      load(0, 1'b1, 1'b0, 32'h44, '0, '0);
      bus.mem_resp = 1'b1;
      #1;
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy);
      end
      n_checks++;
      if ({bus.mem_read, bus.mem_write} !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_rw: got %b%b want 00", bus.mem_read, bus.mem_write);
      end
      n_checks++;
      if ({bus.mem_address, bus.mem_wdata, bus.mem_wmask} !== '0) begin
         n_fail++; $display("FAIL rst_bus: got %h want 0", bus.mem_address);
      end
      n_checks++;
      if (bus.req_resp !== '0) begin
         n_fail++; $display("FAIL rst_resp: got %b want 0", bus.req_resp);
      end
      tick();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.grant_id !== '0) begin
         n_fail++;
         $display("FAIL rst_grant: busy %b grant %0d want 0 0", bus.busy, bus.grant_id);
      end
      rst = 1'b0;
      clear_all();
      m_ptr = 0;
      tick();
   endtask

   task automatic test_single_read();
      load(1, 1'b1, 1'b0, 32'h100, '0, '0);
      #1;
      n_checks++;
      if (bus.mem_read !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL sr_early: rd %b busy %b want 0 0", bus.mem_read, bus.busy);
      end
      tick();
      n_checks++;
      if (bus.busy !== 1'b1 || bus.grant_id !== 2'd1) begin
         n_fail++;
         $display("FAIL sr_grant: busy %b grant %0d want 1 1", bus.busy, bus.grant_id);
      end
      n_checks++;
      if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0) begin
         n_fail++;
         $display("FAIL sr_rw: got %b%b want 10", bus.mem_read, bus.mem_write);
      end
      n_checks++;
      if (bus.mem_address !== 32'h100) begin
         n_fail++; $display("FAIL sr_addr: got %h want 100", bus.mem_address);
      end
      for (int c = 0; c < 2; c++) begin
         tick();
         n_checks++;
         if (bus.req_resp !== '0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sr_wait: resp %b busy %b want 0 1", bus.req_resp, bus.busy);
         end
      end
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = 32'hDEADBEEF;
      #1;
      n_checks++;
      if (bus.req_resp !== 4'b0010) begin
         n_fail++; $display("FAIL sr_resp: got %b want 0010", bus.req_resp);
      end
      n_checks++;
      if (bus.req_rdata !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL sr_rdata: got %h want deadbeef", bus.req_rdata);
      end
      tick();
      drop(1);
      bus.mem_resp = 1'b0;
      #1;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.req_resp !== '0 || bus.mem_read !== 1'b0
          || bus.mem_address !== '0) begin
         n_fail++;
         $display("FAIL sr_done: busy %b resp %b rd %b addr %h want idle zeros",
                  bus.busy, bus.req_resp, bus.mem_read, bus.mem_address);
      end
      m_ptr = 2;
   endtask

   task automatic test_write_priority();
      load(0, 1'b1, 1'b1, 32'h40, 32'h12345678, 4'hF);
      tick();
      n_checks++;
      if (bus.grant_id !== 2'd0 || bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin
         n_fail++;
         $display("FAIL wp_rw: grant %0d rd %b wr %b want 0 0 1",
                  bus.grant_id, bus.mem_read, bus.mem_write);
      end
      n_checks++;
      if (bus.mem_wdata !== 32'h12345678 || bus.mem_wmask !== 4'hF) begin
         n_fail++;
         $display("FAIL wp_data: got %h/%h want 12345678/f", bus.mem_wdata, bus.mem_wmask);
      end
      bus.mem_resp = 1'b1;
      #1;
      n_checks++;
      if (bus.req_resp !== 4'b0001) begin
         n_fail++; $display("FAIL wp_resp: got %b want 0001", bus.req_resp);
      end
      tick();
      drop(0);
      bus.mem_resp = 1'b0;
      m_ptr = 1;
   endtask

   task automatic test_round_robin();
      int exp;
      load(0, 1'b1, 1'b0, 32'h200, '0, '0);
      load(1, 1'b1, 1'b0, 32'h300, '0, '0);
      for (int j = 0; j < 6; j++) begin
         #1;
         n_checks++;
         if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL rr_bubble%0d: busy %b want 0", j, bus.busy);
         end
         exp = pick(4'b0011, m_ptr);
         tick();
         n_checks++;
         if (bus.busy !== 1'b1 || bus.grant_id !== 2'(exp)) begin
            n_fail++;
            $display("FAIL rr_grant%0d: busy %b grant %0d want 1 %0d",
                     j, bus.busy, bus.grant_id, exp);
         end
         n_checks++;
         if (bus.mem_address !== p_a[exp]) begin
            n_fail++;
            $display("FAIL rr_addr%0d: got %h want %h", j, bus.mem_address, p_a[exp]);
         end
         bus.mem_resp = 1'b1;
         #1;
         n_checks++;
         if (bus.req_resp !== 4'(1 << exp)) begin
            n_fail++;
            $display("FAIL rr_resp%0d: got %b want %b", j, bus.req_resp, 4'(1 << exp));
         end
         tick();
         bus.mem_resp = 1'b0;
         m_ptr = (exp + 1) % N;
      end
      drop(0);
      drop(1);
      tick();
   endtask

   task automatic test_reset_mid();
      int exp;
      load(1, 1'b1, 1'b0, 32'h500, '0, '0);
      exp = pick(4'b0010, m_ptr);
      tick();
      n_checks++;
      if (bus.busy !== 1'b1 || bus.grant_id !== 2'(exp)) begin
         n_fail++;
         $display("FAIL rm_grant: busy %b grant %0d want 1 %0d", bus.busy, bus.grant_id, exp);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drop(1);
      #1;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.req_resp !== '0) begin
         n_fail++;
         $display("FAIL rm_after: busy %b resp %b want 0 0", bus.busy, bus.req_resp);
      end
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = 32'hCAFEF00D;
      #1;
      n_checks++;
      if (bus.req_resp !== '0) begin
         n_fail++; $display("FAIL rm_late_resp: got %b want 0", bus.req_resp);
      end
      tick();
      bus.mem_resp = 1'b0;
      #1;
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL rm_idle: busy %b want 0", bus.busy);
      end
      m_ptr = 0;
      load(0, 1'b1, 1'b0, 32'h600, '0, '0);
      load(1, 1'b1, 1'b0, 32'h700, '0, '0);
      exp = pick(4'b0011, m_ptr);
      tick();
      n_checks++;
      if (bus.busy !== 1'b1 || bus.grant_id !== 2'(exp)) begin
         n_fail++;
         $display("FAIL rm_next: busy %b grant %0d want 1 %0d", bus.busy, bus.grant_id, exp);
      end
      bus.mem_resp = 1'b1;
      #1;
      n_checks++;
      if (bus.req_resp !== 4'(1 << exp)) begin
         n_fail++; $display("FAIL rm_resp: got %b want %b", bus.req_resp, 4'(1 << exp));
      end
      tick();
      bus.mem_resp = 1'b0;
      drop(0);
      drop(1);
      m_ptr = (exp + 1) % N;
      tick();
   endtask

   task automatic test_wrap();
      int exp;
      logic [N-1:0] mask;
      load(1, 1'b1, 1'b0, 32'h800, '0, '0);
      exp = pick(4'b0010, m_ptr);
      tick();
      n_checks++;
      if (bus.grant_id !== 2'(exp)) begin
         n_fail++; $display("FAIL wr_pre: grant %0d want %0d", bus.grant_id, exp);
      end
      bus.mem_resp = 1'b1;
      tick();
      bus.mem_resp = 1'b0;
      drop(1);
      m_ptr = (exp + 1) % N;
      mask = 4'b1010;
      load(1, 1'b1, 1'b0, 32'h810, '0, '0);
      load(3, 1'b0, 1'b1, 32'h830, 32'hA5A5A5A5, 4'h3);
      bus.mem_resp = 1'b1;
      #1;
      n_checks++;
      if (bus.req_resp !== '0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_spurious: resp %b busy %b want 0 0", bus.req_resp, bus.busy);
      end
      for (int t = 0; t < 2; t++) begin
         exp = pick(mask, m_ptr);
         tick();
         bus.mem_resp = 1'b0;
         #1;
         n_checks++;
         if (bus.busy !== 1'b1 || bus.grant_id !== 2'(exp)) begin
            n_fail++;
            $display("FAIL wr_grant%0d: busy %b grant %0d want 1 %0d",
                     t, bus.busy, bus.grant_id, exp);
         end
         bus.mem_resp = 1'b1;
         #1;
         n_checks++;
         if (bus.req_resp !== 4'(1 << exp)) begin
            n_fail++;
            $display("FAIL wr_resp%0d: got %b want %b", t, bus.req_resp, 4'(1 << exp));
         end
         tick();
         bus.mem_resp = 1'b0;
         drop(exp);
         mask[exp] = 1'b0;
         m_ptr = (exp + 1) % N;
         #1;
         n_checks++;
         if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL wr_bubble%0d: busy %b want 0", t, bus.busy);
         end
      end
      tick();
   endtask

   task automatic test_random();
      bit           pend [N];
      int           wcnt [N];
      bit           m_busy;
      int           m_grant;
      int           m_lat;
      int           kind;
      int           done_p;
      logic         resp;
      logic [N-1:0] mask;
      logic [N-1:0] er;
      m_busy  = 1'b0;
      m_grant = 0;
      m_lat   = 0;
      for (int p = 0; p < N; p++) begin
         pend[p] = 1'b0;
         wcnt[p] = 0;
      end
      for (int cyc = 0; cyc < 500; cyc++) begin
         for (int p = 0; p < N; p++) begin
            if (!pend[p] && $urandom_range(0, 3) == 0) begin
               kind = int'($urandom_range(1, 3));
               load(p, kind[0], kind[1], $urandom, $urandom, 4'($urandom));
               pend[p] = 1'b1;
               wcnt[p] = 0;
            end
         end
         if (m_busy) resp = (m_lat == 0);
         else resp = ($urandom_range(0, 7) == 0);
         bus.mem_resp  = resp;
         bus.mem_rdata = $urandom;
         #1;
         n_checks++;
         if (bus.busy !== m_busy) begin
            n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, bus.busy, m_busy);
         end
         if (m_busy) begin
            n_checks++;
            if (bus.grant_id !== 2'(m_grant)
                || bus.mem_read !== (p_rd[m_grant] & ~p_wr[m_grant])
                || bus.mem_write !== p_wr[m_grant]) begin
               n_fail++;
               $display("FAIL rnd_ctl c%0d: grant %0d rd %b wr %b want %0d %b %b",
                        cyc, bus.grant_id, bus.mem_read, bus.mem_write, m_grant,
                        p_rd[m_grant] & ~p_wr[m_grant], p_wr[m_grant]);
            end
            n_checks++;
            if (bus.mem_address !== p_a[m_grant] || bus.mem_wdata !== p_d[m_grant]
                || bus.mem_wmask !== p_m[m_grant]) begin
               n_fail++;
               $display("FAIL rnd_bus c%0d: got %h/%h/%h want %h/%h/%h", cyc,
                        bus.mem_address, bus.mem_wdata, bus.mem_wmask,
                        p_a[m_grant], p_d[m_grant], p_m[m_grant]);
            end
         end else begin
            n_checks++;
            if ({bus.mem_read, bus.mem_write} !== 2'b00 || bus.mem_address !== '0
                || bus.mem_wdata !== '0 || bus.mem_wmask !== '0) begin
               n_fail++;
               $display("FAIL rnd_idle c%0d: rd %b wr %b addr %h want zeros",
                        cyc, bus.mem_read, bus.mem_write, bus.mem_address);
            end
         end
         er = '0;
         if (m_busy && resp) er[m_grant] = 1'b1;
         n_checks++;
         if (bus.req_resp !== er || bus.req_rdata !== bus.mem_rdata) begin
            n_fail++;
            $display("FAIL rnd_resp c%0d: got %b/%h want %b/%h", cyc,
                     bus.req_resp, bus.req_rdata, er, bus.mem_rdata);
         end
         done_p = -1;
         if (m_busy) begin
            if (resp) begin
               done_p     = m_grant;
               pend[m_grant] = 1'b0;
               m_busy     = 1'b0;
               m_ptr      = (m_grant + 1) % N;
            end else begin
               m_lat--;
            end
         end else begin
            for (int p = 0; p < N; p++) mask[p] = pend[p];
            if (mask != '0) begin
               m_grant = pick(mask, m_ptr);
`ifndef MEM_ARB_FIXED_PRIO_EN
               n_checks++;
               if (wcnt[m_grant] > N - 1) begin
                  n_fail++;
                  $display("FAIL rnd_fair c%0d: port %0d waited %0d grants want <= %0d",
                           cyc, m_grant, wcnt[m_grant], N - 1);
               end
`endif
               for (int p = 0; p < N; p++) begin
                  if (pend[p] && p != m_grant) wcnt[p]++;
               end
               m_busy = 1'b1;
               m_lat  = int'($urandom_range(0, 3));
            end
         end
         tick();
         bus.mem_resp = 1'b0;
         if (done_p >= 0) drop(done_p);
      end
   endtask

   initial begin
      rst = 1'b1;
      clear_all();
      test_reset();
      test_single_read();
      test_write_priority();
      test_round_robin();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
